// File: rtl/pio_bus_pkg.sv
// Shared types and constants for the Avalon-MM PIO master.
package pio_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    LAT  = 2'd2,
    RESP = 2'd3
  } state_e;

  localparam int DEF_ADDR_W = 2;
  localparam int DEF_DATA_W = 32;
  localparam int CNT_W      = 16;

  localparam logic STROBE_IDLE = 1'b1;

endpackage

// File: rtl/avmm_pio_master_if.sv
// Command/response handshake plus Avalon-MM bus signals of the PIO master.
interface avmm_pio_master_if
  import pio_bus_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) ();

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_timeout;

  logic [ADDR_W-1:0] address;
  logic              chipselect;
  logic              write_n;
  logic              read_n;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata;
  logic              waitrequest;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
           readdata, waitrequest,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_timeout,
           address, chipselect, write_n, read_n, writedata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
           readdata, waitrequest,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_timeout,
           address, chipselect, write_n, read_n, writedata
  );

endinterface

// File: rtl/avmm_pio_master.sv
// Single-outstanding Avalon-MM initiator: one command in, one bus transaction,
// one response out, with waitrequest timeout and fixed read latency.
module avmm_pio_master
  import pio_bus_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int READ_LATENCY = 1,
  parameter int TIMEOUT      = 255
) (
  input  logic clk,
  input  logic reset,
  avmm_pio_master_if.master bus
);

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] LAT_LAST  = CNT_W'(READ_LATENCY - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              write_q, write_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              timeout_q, timeout_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      write_q   <= 1'b0;
      rdata_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      write_q   <= write_d;
      rdata_q   <= rdata_d;
      timeout_q <= timeout_d;
    end
  end

  // One counter serves both the waitrequest budget in BUS and the read
  // latency in LAT; it restarts from zero on entry to each of those states.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    write_d   = write_q;
    rdata_d   = rdata_q;
    timeout_d = timeout_q;

    unique case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          write_d = bus.cmd_write;
          addr_d  = bus.cmd_addr;
          wdata_d = bus.cmd_wdata;
          cnt_d   = '0;
          state_d = BUS;
        end
      end
      BUS: begin
        if (!bus.waitrequest) begin
          if (write_q) begin
            rdata_d = '0;
            state_d = RESP;
          end else if (READ_LATENCY == 0) begin
            rdata_d = bus.readdata;
            state_d = RESP;
          end else begin
            cnt_d   = '0;
            state_d = LAT;
          end
        end else if (cnt_q == TIMEOUT_C) begin
          timeout_d = 1'b1;
          rdata_d   = '0;
          state_d   = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      LAT: begin
        if (cnt_q == LAT_LAST) begin
          rdata_d = bus.readdata;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          timeout_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Strobes decode straight from the state register so reset drops them
  // without waiting for a clock edge.
  assign bus.cmd_ready   = (state_q == IDLE);
  assign bus.rsp_valid   = (state_q == RESP);
  assign bus.rsp_rdata   = rdata_q;
  assign bus.rsp_timeout = timeout_q;
  assign bus.address     = addr_q;
  assign bus.writedata   = wdata_q;
  assign bus.chipselect  = (state_q == BUS);
  assign bus.write_n     = (state_q == BUS &&  write_q) ? ~STROBE_IDLE : STROBE_IDLE;
  assign bus.read_n      = (state_q == BUS && !write_q) ? ~STROBE_IDLE : STROBE_IDLE;

endmodule

// File: tb/tb_avmm_pio_master.sv
// Directed bench for avmm_pio_master against a one-register PIO slave model.
module tb_avmm_pio_master;

  localparam int AW = 2;
  localparam int DW = 32;
  localparam int RL = 1;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic stall = 1'b0;
  logic [DW-1:0] out_port_q;
  logic [DW-1:0] rd_q;

  int total = 0;
  int bad = 0;

  avmm_pio_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  avmm_pio_master #(
    .ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(RL), .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // PIO slave: out_port register at address 0, registered read data.
  assign bus.waitrequest = stall;
  assign bus.readdata    = rd_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_port_q <= '0;
      rd_q       <= '0;
    end else if (bus.chipselect && !stall) begin
      if (!bus.write_n && bus.address == 2'd0) out_port_q <= bus.writedata;
      if (!bus.read_n) rd_q <= (bus.address == 2'd0) ? out_port_q : '0;
    end
  end

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            n_wait;
    int            hold;
    logic [DW-1:0] exp_rdata;
    logic          exp_to;
    int            exp_rsp_cyc;
    int            exp_bus_cyc;
    logic [DW-1:0] exp_port;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int cyc;
    int nbus;
    logic got;
    logic [DW-1:0] held;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = v.wr;
    bus.cmd_addr  = v.addr;
    bus.cmd_wdata = v.wdata;
    check("cmd_ready_offer", 32'(bus.cmd_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    cyc  = 1;
    nbus = 0;
    got  = 1'b0;
    while (!got && cyc < 40) begin
      if (bus.rsp_valid) begin
        got = 1'b1;
      end else begin
        if (bus.chipselect) begin
          check("bus_signals",
                {bus.write_n, bus.read_n, 28'(bus.address)},
                {~v.wr, v.wr, 28'(v.addr)});
          check("bus_wdata", bus.writedata, v.wdata);
          stall = (nbus < v.n_wait);
          nbus++;
        end else begin
          check("idle_strobes", {30'd0, bus.write_n, bus.read_n}, 32'd3);
          stall = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
      end
    end
    stall = 1'b0;
    check("rsp_seen", 32'(got), 32'd1);
    check("rsp_cycle", 32'(cyc), 32'(v.exp_rsp_cyc));
    check("bus_cycles", 32'(nbus), 32'(v.exp_bus_cyc));
    check("rsp_rdata", bus.rsp_rdata, v.exp_rdata);
    check("rsp_timeout", 32'(bus.rsp_timeout), 32'(v.exp_to));
    check("resp_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    check("resp_strobes", {29'd0, bus.chipselect, bus.write_n, bus.read_n}, 32'd3);
    held = bus.rsp_rdata;
    // Offer a stray command while the response is pending; it must be ignored.
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b1;
    bus.cmd_addr  = 2'd0;
    bus.cmd_wdata = 32'h0BAD_0BAD;
    for (int i = 0; i < v.hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("hold_valid_ready", {30'd0, bus.rsp_valid, bus.cmd_ready}, 32'd2);
      check("hold_rdata", bus.rsp_rdata, held);
      check("hold_timeout", 32'(bus.rsp_timeout), 32'(v.exp_to));
      check("hold_cs", 32'(bus.chipselect), 32'd0);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    bus.cmd_valid = 1'b0;
    check("post_valid_ready", {30'd0, bus.rsp_valid, bus.cmd_ready}, 32'd1);
    check("post_timeout_cs", {30'd0, bus.rsp_timeout, bus.chipselect}, 32'd0);
    check("post_rdata_held", bus.rsp_rdata, v.exp_rdata);
    check("out_port", out_port_q, v.exp_port);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    //                wr    addr  wdata          wait hold rdata          to    rsp bus port
    vecs[0] = '{1'b1, 2'd0, 32'hDEADBEEF, 0,   0, 32'h0,        1'b0, 2, 1, 32'hDEADBEEF};
    vecs[1] = '{1'b0, 2'd0, 32'h0,        0,   0, 32'hDEADBEEF, 1'b0, 3, 1, 32'hDEADBEEF};
    vecs[2] = '{1'b0, 2'd1, 32'h0,        0,   0, 32'h0,        1'b0, 3, 1, 32'hDEADBEEF};
    vecs[3] = '{1'b1, 2'd0, 32'h12345678, 3,   0, 32'h0,        1'b0, 5, 4, 32'h12345678};
    vecs[4] = '{1'b0, 2'd0, 32'h0,        2,   5, 32'h12345678, 1'b0, 5, 3, 32'h12345678};
    vecs[5] = '{1'b0, 2'd0, 32'h0,        100, 0, 32'h0,        1'b1, 6, 5, 32'h12345678};
    vecs[6] = '{1'b1, 2'd2, 32'hCAFEF00D, 100, 2, 32'h0,        1'b1, 6, 5, 32'h12345678};
    vecs[7] = '{1'b1, 2'd0, 32'h000000A5, 4,   0, 32'h0,        1'b0, 6, 5, 32'h000000A5};
    vecs[8] = '{1'b0, 2'd0, 32'h0,        0,   1, 32'h000000A5, 1'b0, 3, 1, 32'h000000A5};

    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.rsp_ready = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_ready_valid", {30'd0, bus.cmd_ready, bus.rsp_valid}, 32'd2);
    check("rst_rdata", bus.rsp_rdata, 32'd0);
    check("rst_timeout", 32'(bus.rsp_timeout), 32'd0);
    check("rst_strobes", {29'd0, bus.chipselect, bus.write_n, bus.read_n}, 32'd3);
    check("rst_address", 32'(bus.address), 32'd0);
    check("rst_writedata", bus.writedata, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 9; i++) run_vec(vecs[i]);

    // Reset in the middle of a stalled write.
    stall = 1'b1;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b1;
    bus.cmd_addr  = 2'd1;
    bus.cmd_wdata = 32'h55AA55AA;
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    check("mid_write_n", 32'(bus.write_n), 32'd0);
    @(posedge clk);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("arst_strobes", {29'd0, bus.chipselect, bus.write_n, bus.read_n}, 32'd3);
    check("arst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    stall = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("after_rst", {29'd0, bus.cmd_ready, bus.rsp_valid, bus.chipselect}, 32'd4);
    end
    check("after_rst_port", out_port_q, 32'd0);
    vecs[0].exp_port = 32'hDEADBEEF;
    run_vec(vecs[0]);
    run_vec(vecs[1]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/avmm_pio_master.md
Name: avmm_pio_master

Overview:
- Avalon-MM initiator that lets user logic (camera/control datapath) read and write single-register PIO-style slaves, such as operand/output registers, without a Nios II in the loop.
- Accepts one command at a time over a valid/ready interface, runs one bus transaction with waitrequest and fixed read latency, and returns one response over valid/ready.
- Sits between a hardware sequencer and the system interconnect slave port of any 32-bit PIO.

Parameters:
ADDR_W, 2, bus address width (word address)
DATA_W, 32, bus data width
READ_LATENCY, 1, fixed slave read latency in cycles after the read is accepted (0..7)
TIMEOUT, 255, maximum waitrequest cycles before the transaction is abandoned (1..65535)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when high with cmd_valid
cmd_write  in  1  1=write, 0=read
cmd_addr  in  ADDR_W  target address
cmd_wdata  in  DATA_W  write data
rsp_valid  out  1  response available
rsp_ready  in  1  response consumed
rsp_rdata  out  DATA_W  read data (0 for writes and timeouts)
rsp_timeout  out  1  transaction abandoned after TIMEOUT
address  out  ADDR_W  Avalon address
chipselect  out  1  Avalon chipselect
write_n  out  1  Avalon write strobe, active-low
read_n  out  1  Avalon read strobe, active-low
writedata  out  DATA_W  Avalon write data
readdata  in  DATA_W  Avalon read data
waitrequest  in  1  Avalon stall

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset values: state IDLE; cmd_ready=1; rsp_valid=0; rsp_rdata=0; rsp_timeout=0; chipselect=0; write_n=1; read_n=1; address=0; writedata=0; wait counter=0.
- States: IDLE, BUS, LAT, RESP.
- IDLE:
  - cmd_ready=1.
  - On the accept edge (cmd_valid&cmd_ready), latch cmd_write, cmd_addr and cmd_wdata into the address/writedata registers, then go to BUS.
- BUS:
  - chipselect=1.
  - write_n=0 on writes; read_n=0 on reads.
  - address and writedata are held stable.
  - cmd_ready=0 in every state except IDLE.
- Completion: a BUS cycle with waitrequest=0 completes the transaction, and all strobes deassert on the next cycle.
  - Write: go to RESP, rsp_rdata=0.
  - Read, READ_LATENCY=0: capture readdata on the same edge, go to RESP.
  - Read, READ_LATENCY>=1: go to LAT, count READ_LATENCY cycles, capture readdata on the final LAT edge, go to RESP.
- Stalls:
  - Each BUS cycle with waitrequest=1 increments the wait counter.
  - When the counter equals TIMEOUT while waitrequest=1: deassert strobes, set rsp_timeout=1 and rsp_rdata=0, go to RESP.
  - The counter clears on entry to BUS.
- RESP:
  - rsp_valid=1, with rsp_rdata and rsp_timeout held stable until rsp_ready=1.
  - On that edge, rsp_valid drops, rsp_timeout clears, and the state goes to IDLE. rsp_rdata holds its last value.
  - No new command is accepted in the same cycle; cmd_ready rises the cycle after the handshake.
- Latency, from accept edge at cycle 0 with no waits:
  - Write: strobe in cycle 1, rsp_valid in cycle 2.
  - Read: rsp_valid in cycle 2+READ_LATENCY.
- Only one transaction is outstanding at a time. Strobes are never asserted outside BUS.
- Reset mid-transaction: strobes deassert asynchronously and any pending response is discarded. No response is generated after reset.
- cmd_* inputs are ignored outside IDLE. A waitrequest of X outside BUS must not affect state.

Decomposition:
- Shared package (pio_bus_pkg):
  - state encoding constants IDLE/BUS/LAT/RESP
  - default ADDR_W/DATA_W
  - Avalon strobe idle levels (write_n/read_n = 1)
- Single module. No sub-module is needed; the wait and latency counters stay inline and share one counter register.

Test Plan:
1. Write, no wait: cmd write addr=0 data=0xDEADBEEF -> chipselect=1 and write_n=0 for exactly cycle 1, writedata=0xDEADBEEF; rsp_valid in cycle 2 with rsp_rdata=0 and rsp_timeout=0; a PIO slave model's out_port=0xDEADBEEF.
2. Read after write, READ_LATENCY=1: read addr=0 -> read_n=0 in cycle 1; rsp_valid in cycle 3 with rsp_rdata=0xDEADBEEF. Read addr=1 -> rsp_rdata=0.
3. Waitrequest stall: waitrequest=1 for 3 cycles then 0 -> strobes held 4 cycles with address and writedata stable; rsp_valid one cycle after the release; rsp_timeout=0.
4. Timeout, TIMEOUT=4: waitrequest stuck at 1 -> strobes deassert after 5 BUS cycles; rsp_valid=1, rsp_timeout=1, rsp_rdata=0.
5. Response backpressure: rsp_ready=0 for 5 cycles -> rsp_valid and rsp_rdata stable, cmd_ready=0 throughout, cmd_valid ignored; cmd_ready=1 the cycle after rsp_ready=1.
6. Reset mid-BUS: assert reset while write_n=0 -> write_n=1, chipselect=0 and rsp_valid=0 immediately without a clock edge; after release, cmd_ready=1 and no stray response appears.
